// File: rtl/xgs_hispi_pkg.sv
// Shared HiSPi lane definitions: sync codes, FSM state type and sync word lookup.
// Used by xgs_hispi_lane_tx and xgs_hispi_sync_gen.
package xgs_hispi_pkg;

    localparam logic [11:0] IDLE_WORD_DEF = 12'h3A6;
    localparam logic [11:0] SYNC_PRE0     = 12'hFFF;
    localparam logic [11:0] SYNC_PRE1     = 12'h000;
    localparam logic [11:0] CODE_SOF      = 12'h800;
    localparam logic [11:0] CODE_SOL      = 12'h880;
    localparam logic [11:0] CODE_EOL      = 12'hA00;
    localparam logic [11:0] CODE_EOF      = 12'hA80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC_START,
        ST_PIXELS,
        ST_SYNC_END,
        ST_BLANK
    } state_t;

    // Sync sequence is FFF, 000, 000, code.
    function automatic logic [11:0] sync_word(input logic [1:0] idx, input logic [11:0] code);
        case (idx)
            2'd0:    sync_word = SYNC_PRE0;
            2'd3:    sync_word = code;
            default: sync_word = SYNC_PRE1;
        endcase
    endfunction

endpackage

// File: rtl/xgs_hispi_sync_gen.sv
// Four-word HiSPi sync sequencer: each step emits the current word and advances.
// The index wraps to 0 after the code word so the next sequence starts clean.
module xgs_hispi_sync_gen
    import xgs_hispi_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_reset_n,
    input  logic        step,
    input  logic [11:0] code,
    output logic [11:0] word,
    output logic        last
);

    logic [1:0] idx;

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            idx <= '0;
        end else if (step) begin
            idx <= idx + 2'd1;
        end
    end

    assign word = sync_word(idx, code);
    assign last = (idx == 2'd3);

endmodule

// File: rtl/xgs_hispi_lane_tx.sv
// Single-lane HiSPi packetized-SP word generator (frame/line framing, one word per clock).
// Optional per-line XOR checksum word after EOL/EOF when XGS_HISPI_LANE_TX_CHKSUM_EN is defined.
//
// state         | meaning
// ST_IDLE       | emit IDLE_WORD, wait for start; finishes frame_done/busy handoff
// ST_SYNC_START | emit FFF,000,000,SOF/SOL
// ST_PIXELS     | pix_ready high, forward pixel words (repeat on underrun)
// ST_SYNC_END   | emit FFF,000,000,EOL/EOF (plus checksum word if enabled)
// ST_BLANK      | emit IDLE_WORD for hblank cycles between lines
module xgs_hispi_lane_tx
    import xgs_hispi_pkg::*;
#(
    parameter int          PIX_W     = 12,
    parameter logic [11:0] IDLE_WORD = IDLE_WORD_DEF,
    parameter int          LINE_W    = 13,
    parameter int          FRAME_W   = 12
) (
    input  logic               sys_clk,
    input  logic               sys_reset_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] cfg_line_count,
    input  logic [LINE_W-1:0]  cfg_line_words,
    input  logic [9:0]         cfg_hblank,
    input  logic [PIX_W-1:0]   pix_data,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [PIX_W-1:0]   tx_data,
    output logic               tx_valid,
    output logic               busy,
    output logic               frame_done,
    output logic               underrun_err,
    output logic               cfg_err
);

    state_t             state;
    logic [LINE_W-1:0]  words_q;
    logic [LINE_W-1:0]  word_cnt;
    logic [FRAME_W-1:0] lines_q;
    logic [FRAME_W-1:0] line_cnt;
    logic [9:0]         hblank_q;
    logic [9:0]         blank_cnt;
    logic               fin_pend;
    logic               start_ok;
    logic               last_line;
    logic               sync_step;
    logic               sync_last;
    logic               seg_end;
    logic [11:0]        sync_code;
    logic [11:0]        sync_w;
    logic [PIX_W-1:0]   pix_word;
`ifdef XGS_HISPI_LANE_TX_CHKSUM_EN
    logic [PIX_W-1:0]   chk;
    logic               chk_phase;
`endif

    assign start_ok  = (state == ST_IDLE) && !fin_pend && start &&
                       (cfg_line_count != '0) && (cfg_line_words != '0);
    assign last_line = (line_cnt == lines_q - FRAME_W'(1));
    assign pix_ready = (state == ST_PIXELS);
    assign pix_word  = pix_valid ? pix_data : tx_data;

`ifdef XGS_HISPI_LANE_TX_CHKSUM_EN
    assign sync_step = start_ok || (state == ST_SYNC_START) || ((state == ST_SYNC_END) && !chk_phase);
    assign seg_end   = (state == ST_SYNC_END) && chk_phase;
`else
    assign sync_step = start_ok || (state == ST_SYNC_START) || (state == ST_SYNC_END);
    assign seg_end   = (state == ST_SYNC_END) && sync_last;
`endif

    always_comb begin
        sync_code = CODE_SOF;
        if (state == ST_SYNC_START) begin
            sync_code = (line_cnt == '0) ? CODE_SOF : CODE_SOL;
        end else if (state == ST_SYNC_END) begin
            sync_code = last_line ? CODE_EOF : CODE_EOL;
        end
    end

    xgs_hispi_sync_gen u_sync_gen (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .step        (sync_step),
        .code        (sync_code),
        .word        (sync_w),
        .last        (sync_last)
    );

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state        <= ST_IDLE;
            tx_data      <= IDLE_WORD;
            tx_valid     <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            underrun_err <= 1'b0;
            cfg_err      <= 1'b0;
            fin_pend     <= 1'b0;
            words_q      <= '0;
            lines_q      <= '0;
            hblank_q     <= '0;
            word_cnt     <= '0;
            line_cnt     <= '0;
            blank_cnt    <= '0;
`ifdef XGS_HISPI_LANE_TX_CHKSUM_EN
            chk          <= '0;
            chk_phase    <= 1'b0;
`endif
        end else begin
            tx_valid   <= 1'b1;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx_data <= IDLE_WORD;
                    // busy drops together with the frame_done pulse, one cycle after EOF
                    if (fin_pend) begin
                        fin_pend   <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else if (start_ok) begin
                        lines_q  <= cfg_line_count;
                        words_q  <= cfg_line_words;
                        hblank_q <= cfg_hblank;
                        line_cnt <= '0;
                        busy     <= 1'b1;
                        tx_data  <= sync_w;
                        state    <= ST_SYNC_START;
                    end else if (start) begin
                        cfg_err <= 1'b1;
                    end
                end
                ST_SYNC_START: begin
                    tx_data  <= sync_w;
                    word_cnt <= '0;
`ifdef XGS_HISPI_LANE_TX_CHKSUM_EN
                    chk      <= '0;
`endif
                    if (sync_last) state <= ST_PIXELS;
                end
                ST_PIXELS: begin
                    tx_data <= pix_word;
                    if (!pix_valid) underrun_err <= 1'b1;
`ifdef XGS_HISPI_LANE_TX_CHKSUM_EN
                    chk <= chk ^ pix_word;
`endif
                    if (word_cnt == words_q - LINE_W'(1)) begin
                        state <= ST_SYNC_END;
                    end else begin
                        word_cnt <= word_cnt + LINE_W'(1);
                    end
                end
                ST_SYNC_END: begin
`ifdef XGS_HISPI_LANE_TX_CHKSUM_EN
                    tx_data   <= chk_phase ? chk : sync_w;
                    chk_phase <= !chk_phase && sync_last;
`else
                    tx_data <= sync_w;
`endif
                    if (seg_end) begin
                        if (last_line) begin
                            state    <= ST_IDLE;
                            fin_pend <= 1'b1;
                        end else begin
                            line_cnt  <= line_cnt + FRAME_W'(1);
                            blank_cnt <= '0;
                            state     <= (hblank_q == '0) ? ST_SYNC_START : ST_BLANK;
                        end
                    end
                end
                ST_BLANK: begin
                    tx_data <= IDLE_WORD;
                    if (blank_cnt == hblank_q - 10'd1) begin
                        state <= ST_SYNC_START;
                    end else begin
                        blank_cnt <= blank_cnt + 10'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xgs_hispi_lane_tx.sv
// Self-checking bench for xgs_hispi_lane_tx: queue-based frame model plus literal spot checks.
module tb_xgs_hispi_lane_tx;

    localparam logic [11:0] IW    = 12'h3A6;
    localparam int          K_FIX = 0;
    localparam int          K_PIX = 1;
    localparam int          K_CHK = 2;

    localparam logic [11:0] LIT1 [27] = '{
        12'hFFF, 12'h000, 12'h000, 12'h800, 12'h001, 12'h002, 12'h003, 12'h004,
        12'hFFF, 12'h000, 12'h000, 12'hA00, 12'h3A6, 12'h3A6, 12'h3A6,
        12'hFFF, 12'h000, 12'h000, 12'h880, 12'h005, 12'h006, 12'h007, 12'h008,
        12'hFFF, 12'h000, 12'h000, 12'hA80};
    localparam logic [11:0] LITC [11] = '{
        12'hFFF, 12'h000, 12'h000, 12'h800, 12'h0F0, 12'h00F,
        12'hFFF, 12'h000, 12'h000, 12'hA80, 12'h0FF};
    localparam logic [11:0] LITU [4] = '{12'h010, 12'h010, 12'h011, 12'h012};

    logic        sys_clk = 1'b0;
    logic        sys_reset_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] cfg_line_count = '0;
    logic [12:0] cfg_line_words = '0;
    logic [9:0]  cfg_hblank = '0;
    logic [11:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [11:0] tx_data;
    logic        tx_valid, busy, frame_done, underrun_err, cfg_err;

    xgs_hispi_lane_tx dut (
        .sys_clk        (sys_clk),
        .sys_reset_n    (sys_reset_n),
        .start          (start),
        .cfg_line_count (cfg_line_count),
        .cfg_line_words (cfg_line_words),
        .cfg_hblank     (cfg_hblank),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .busy           (busy),
        .frame_done     (frame_done),
        .underrun_err   (underrun_err),
        .cfg_err        (cfg_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [11:0] val;
        int          kind;
        bit          busy;
        bit          done;
    } ent_t;

    ent_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [11:0] last_tx = IW;
    logic [11:0] chk_acc = '0;
    bit          exp_under = 0;
    bit          exp_cfgerr = 0;
    bit          exp_txv = 0;

    int          src_mode = 0;
    logic [11:0] src_val = '0;
    int          rdy_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic push(input logic [11:0] v, input int k, input bit b, input bit d);
        ent_t e;
        e.val = v; e.kind = k; e.busy = b; e.done = d;
        q.push_back(e);
    endtask

    // Whole-frame word schedule, one entry per tx cycle starting the cycle after start.
    task automatic build_frame(input int lc, input int lw, input int hb);
        for (int l = 0; l < lc; l++) begin
            push(12'hFFF, K_FIX, 1, 0); push(12'h000, K_FIX, 1, 0); push(12'h000, K_FIX, 1, 0);
            push((l == 0) ? 12'h800 : 12'h880, K_FIX, 1, 0);
            for (int w = 0; w < lw; w++) push(12'h000, K_PIX, 1, 0);
            push(12'hFFF, K_FIX, 1, 0); push(12'h000, K_FIX, 1, 0); push(12'h000, K_FIX, 1, 0);
            push((l == lc - 1) ? 12'hA80 : 12'hA00, K_FIX, 1, 0);
`ifdef XGS_HISPI_LANE_TX_CHKSUM_EN
            push(12'h000, K_CHK, 1, 0);
`endif
            if (l != lc - 1) for (int b = 0; b < hb; b++) push(IW, K_FIX, 1, 0);
        end
        push(IW, K_FIX, 0, 1);
    endtask

    // Model update at each clock edge using only bench-driven inputs.
    initial begin : model
        logic [11:0] w;
        forever begin
            @(posedge sys_clk or negedge sys_reset_n);
            if (!sys_reset_n) begin
                q.delete();
                exp_under = 0; exp_cfgerr = 0; exp_txv = 0;
                chk_acc = '0; last_tx = IW;
            end else begin
                exp_txv = 1;
                exp_cfgerr = 0;
                if (q.size() > 0 && q[0].kind == K_PIX) begin
                    w = pix_valid ? pix_data : last_tx;
                    q[0].val = w;
                    chk_acc = chk_acc ^ w;
                    if (!pix_valid) exp_under = 1;
                end else if (q.size() > 0 && q[0].kind == K_CHK) begin
                    q[0].val = chk_acc;
                    chk_acc = '0;
                end
                if (start && q.size() == 0) begin
                    if (cfg_line_count == 0 || cfg_line_words == 0) exp_cfgerr = 1;
                    else build_frame(int'(cfg_line_count), int'(cfg_line_words), int'(cfg_hblank));
                end
            end
        end
    end

    initial begin : compare
        ent_t e;
        bit   er;
        forever begin
            @(negedge sys_clk);
            if (q.size() > 0) e = q.pop_front();
            else begin e.val = IW; e.kind = K_FIX; e.busy = 0; e.done = 0; end
            er = (q.size() > 0) && (q[0].kind == K_PIX);
            check("tx_data", tx_data, e.val);
            check("busy", busy, e.busy);
            check("frame_done", frame_done, e.done);
            check("pix_ready", pix_ready, er);
            check("tx_valid", tx_valid, exp_txv);
            check("underrun_err", underrun_err, exp_under);
            check("cfg_err", cfg_err, exp_cfgerr);
            last_tx = e.val;
        end
    end

    initial begin : source
        bit rdy_s;
        forever begin
            @(negedge sys_clk);
            rdy_s = pix_ready;
            @(posedge sys_clk);
            #1;
            if (pix_valid && rdy_s) begin
                case (src_mode)
                    1:       src_val = 12'($urandom);
                    3:       src_val = src_val ^ 12'h0FF;
                    default: src_val = src_val + 12'd1;
                endcase
            end
            if (rdy_s) rdy_seen++;
            pix_data = src_val;
            case (src_mode)
                1:       pix_valid = ($urandom_range(0, 3) != 0);
                2:       pix_valid = (rdy_seen != 1);
                default: pix_valid = 1'b1;
            endcase
        end
    end

    task automatic pulse_start();
        @(posedge sys_clk); #1 start = 1'b1;
        @(posedge sys_clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int dones);
        dones = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (frame_done) dones++;
            if (q.size() == 0) return;
        end
        n_tests++; n_fail++;
        $display("FAIL wait_idle timeout after %0d cycles, remaining=%0d expected=0", budget, q.size());
    endtask

    task automatic set_cfg(input int lc, input int lw, input int hb);
        cfg_line_count = 12'(lc);
        cfg_line_words = 13'(lw);
        cfg_hblank     = 10'(hb);
    endtask

    initial begin : watchdog
        #3000000;
        n_fail++;
        $display("FAIL watchdog time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : main
        logic [11:0] cap [32];
        logic        capd [32];
        logic        capb [32];
        int          d;
        bit          found;

        @(negedge sys_clk);
        check("rst_tx", tx_data, 12'h3A6);
        check("rst_busy", busy, 0);
        check("rst_txv", tx_valid, 0);
        @(posedge sys_clk); #1 sys_reset_n = 1'b1;
        @(negedge sys_clk);

`ifndef XGS_HISPI_LANE_TX_CHKSUM_EN
        set_cfg(2, 4, 3); src_mode = 0; src_val = 12'h001;
        pulse_start();
        for (int i = 0; i < 28; i++) begin
            @(negedge sys_clk);
            cap[i] = tx_data; capd[i] = frame_done; capb[i] = busy;
        end
        for (int i = 0; i < 27; i++) check($sformatf("lit1_w%0d", i), cap[i], LIT1[i]);
        check("lit1_done_early", capd[26], 0);
        check("lit1_done", capd[27], 1);
        check("lit1_busy_end", capb[27], 0);
        wait_idle(100, d);
`else
        set_cfg(1, 2, 0); src_mode = 3; src_val = 12'h0F0;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            cap[i] = tx_data; capd[i] = frame_done; capb[i] = busy;
        end
        for (int i = 0; i < 11; i++) check($sformatf("litc_w%0d", i), cap[i], LITC[i]);
        check("litc_done", capd[11], 1);
        wait_idle(100, d);
`endif

        set_cfg(3, 0, 2);
        pulse_start();
        @(negedge sys_clk);
        check("cfgerr_lw0", cfg_err, 1);
        check("cfgerr_lw0_busy", busy, 0);
        check("cfgerr_lw0_tx", tx_data, 12'h3A6);
        set_cfg(0, 5, 2);
        pulse_start();
        @(negedge sys_clk);
        check("cfgerr_lc0", cfg_err, 1);
        check("cfgerr_lc0_busy", busy, 0);

        @(negedge sys_clk);
        set_cfg(2, 4, 0); src_mode = 2; src_val = 12'h010; rdy_seen = 0;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            cap[i] = tx_data; capd[i] = underrun_err;
        end
        for (int i = 0; i < 4; i++) check($sformatf("underrun_w%0d", i), cap[4 + i], LITU[i]);
        check("underrun_eol", cap[11], 12'hA00);
        check("underrun_flag", capd[8], 1);
        wait_idle(100, d);
        check("underrun_sticky", underrun_err, 1);

        @(negedge sys_clk);
        set_cfg(2, 6, 1); src_mode = 0;
        pulse_start();
        repeat (5) @(negedge sys_clk);
        set_cfg(1, 1, 0);
        pulse_start();
        wait_idle(200, d);
        check("midstart_dones", d, 1);

        @(negedge sys_clk);
        set_cfg(3, 10, 2);
        pulse_start();
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge sys_clk);
            if (pix_ready) found = 1;
        end
        if (!found) begin
            n_tests++; n_fail++;
            $display("FAIL reset_wait pix_ready never seen, expected within 50 cycles");
        end
        #2 sys_reset_n = 1'b0;
        @(posedge sys_clk); #1;
        check("rst_mid_tx", tx_data, 12'h3A6);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", pix_ready, 0);
        sys_reset_n = 1'b1;
        @(negedge sys_clk);
        set_cfg(1, 3, 0);
        pulse_start();
        wait_idle(100, d);
        check("post_rst_dones", d, 1);

        for (int it = 0; it < 12; it++) begin
            @(negedge sys_clk);
            set_cfg($urandom_range(1, 4), $urandom_range(1, 20), $urandom_range(0, 5));
            if ($urandom_range(0, 7) == 0) cfg_line_words = '0;
            src_mode = 1;
            pulse_start();
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(2, 10)) @(negedge sys_clk);
                pulse_start();
            end
            wait_idle(2000, d);
        end

        @(negedge sys_clk);
        set_cfg(4095, 1, 0); src_mode = 0;
        pulse_start();
        wait_idle(40000, d);
        check("maxlines_dones", d, 1);

        @(negedge sys_clk);
        set_cfg(2, 8191, 1023); src_mode = 1;
        pulse_start();
        wait_idle(20000, d);
        check("maxwords_dones", d, 1);

        repeat (3) @(negedge sys_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xgs_hispi_lane_tx.md
Name: xgs_hispi_lane_tx

Overview:
Single-lane HiSPi packetized-SP word generator emulating the XGS sensor's transmit side. It frames pixel words into lines and frames with SOF/SOL/EOL/EOF sync sequences and emits one 12-bit word per clock. It sits in the validation environment's sensor-model path and drives the DUT's HiSPi receiver at word level, ahead of any bit serializer. Pixel content comes from an external pattern source over a valid/ready handshake.

Parameters:
PIX_W, 12, word width (fixed protocol width; other values unsupported)
IDLE_WORD, 12'h3A6, word emitted in IDLE and during blanking
LINE_W, 13, width of cfg_line_words
FRAME_W, 12, width of cfg_line_count

Ports:
sys_clk  in  1  system clock
sys_reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when idle
cfg_line_count  in  FRAME_W  lines per frame; sampled on accepted start
cfg_line_words  in  LINE_W  pixel words per line; sampled on accepted start
cfg_hblank  in  10  blanking words after each line; sampled on accepted start
pix_data  in  12  pixel word from the pattern source
pix_valid  in  1  pix_data valid
pix_ready  out  1  block consumes pix_data this cycle
tx_data  out  12  HiSPi word, registered
tx_valid  out  1  high every cycle after reset release
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last word of EOF sync
underrun_err  out  1  sticky; pixel needed while pix_valid low
cfg_err  out  1  one-cycle pulse; start rejected because of zero config

Behaviour:
- Reset: all outputs 0 except tx_data=IDLE_WORD. Reset mid-frame aborts immediately to IDLE with no partial sync. underrun_err clears only on reset.
- Sync sequence: 4 words 12'hFFF, 12'h000, 12'h000, code. Codes are SOF=12'h800, SOL=12'h880, EOL=12'hA00, EOF=12'hA80.
- States are IDLE, SYNC_START, PIXELS, SYNC_END, BLANK.
- IDLE: emits IDLE_WORD. A start with line_count!=0 and line_words!=0 latches config, sets busy, and enters SYNC_START.
  - A start with either value zero is ignored and pulses cfg_err.
  - start while busy is ignored, with no error.
- Latency: start at cycle N -> 12'hFFF on tx_data at N+1.
- SYNC_START: sends the 4-word sync using SOF on line 0 and SOL otherwise, then enters PIXELS.
- PIXELS: pix_ready=1 for exactly line_words cycles, combinational with state.
  - An accepted word appears on tx_data the next cycle.
  - If pix_valid=0 while pix_ready=1, the previous tx word repeats, underrun_err sets, and the counter still advances (line length never stretches).
- SYNC_END: sends EOL on non-final lines and EOF on the final line.
  - After EOL: go to BLANK for hblank cycles (emitting IDLE_WORD), or straight to SYNC_START if hblank=0.
  - After EOF: return to IDLE, pulse frame_done in the cycle after the code word, and drop busy in that same cycle.
- Counters: word counter LINE_W bits and line counter FRAME_W bits, both compared against latched config minus 1. Maximum values (4095 lines, 8191 words) are legal with no wrap.
- Words per line on tx: 4 + line_words + 4 (+1 with option) + hblank.

Optional Feature:
- Macro XGS_HISPI_LANE_TX_CHKSUM_EN.
- Defined: after every EOL/EOF code word, one extra word equal to the XOR of that line's transmitted pixel words. The accumulator clears at SYNC_START.
- Undefined: no checksum word; timing exactly as above.

Decomposition:
- Shared package xgs_hispi_pkg holds:
  - sync code constants (SOF/SOL/EOL/EOF, sync preamble words);
  - the state enum typedef;
  - the IDLE_WORD default;
  - a function returning the sync word for a given index and code.
- One sub-module, xgs_hispi_sync_gen: 2-bit index counter, emits the 4-word sequence on request, and flags the last word. The main block holds the FSM, counters and handshake.

Test Plan:
- line_count=2, line_words=4, hblank=3, ramp pixels 0x001..0x008 always valid. Required tx: FFF,000,000,800,001..004,FFF,000,000,A00, three 3A6 words, FFF,000,000,880,005..008,FFF,000,000,A80. frame_done fires one cycle after the last A80.
- line_words=0 or line_count=0 with start -> cfg_err pulse; busy stays 0; tx stays 3A6.
- pix_valid low on the 2nd pixel cycle of line_words=4, data 0x010,0x011... -> tx 010,010,011,012; underrun_err=1 and stays set; EOL still on schedule.
- start asserted again mid-frame -> ignored; frame length unchanged; only one frame_done.
- Reset asserted during PIXELS -> next edge gives tx=3A6, busy=0, pix_ready=0. A new start runs a clean frame.
- With CHKSUM_EN, line_words=2, pixels 0x0F0,0x00F -> 0x0FF follows the A00/A80 code.
